// File: rtl/rvx_test_host.sv
// RVX dbus test-host peripheral: tohost pass/fail capture, signature pointers, cycle counter, hang timeout.
// Optional random extra wait states when RVX_TEST_HOST_RANDOM_STALL_EN is defined.
module rvx_test_host #(
  parameter int WAIT_STATES    = 1,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        rrequest,
  output logic [31:0] rdata,
  output logic        rresponse,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrobe,
  input  logic        wrequest,
  output logic        wresponse,
  output logic        test_done,
  output logic        test_pass,
  output logic [30:0] fail_code
);

  localparam int unsigned WS_EFF       = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
  localparam logic [31:0] WAIT_LOAD    = 32'(WS_EFF - 1);
  localparam logic [63:0] TIMEOUT_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] wait_cnt, wait_cnt_next;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrobe;
  logic        req_write;

  logic [31:0] tohost, sig_begin, sig_end;
  logic [63:0] cycle_cnt;
  logic [31:0] hi_snap;
  logic        done, pass, timed_out;

  logic        accept, commit, tohost_hit, timeout_hit;
  logic [2:0]  cur_addr;
  logic [31:0] cur_wdata, wmask;
  logic [3:0]  cur_wstrobe;
  logic        cur_write;
  logic [31:0] merged_tohost, merged_begin, merged_end;
  logic [31:0] stall_extra, stall_rd, wait_load, rd_mux;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{address[31:5], address[1:0]};

`ifdef RVX_TEST_HOST_RANDOM_STALL_EN
  logic [15:0] lfsr;
  logic [1:0]  stall_applied;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr          <= 16'hACE1;
      stall_applied <= 2'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (accept) stall_applied <= lfsr[1:0];
    end
  end

  assign stall_extra = {30'd0, lfsr[1:0]};
  assign stall_rd    = {30'd0, stall_applied};
`else
  assign stall_extra = 32'd0;
  assign stall_rd    = 32'd0;
`endif

  assign accept    = (state == IDLE) && (rrequest || wrequest);
  assign wait_load = WAIT_LOAD + stall_extra;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          wait_cnt_next = wait_load;
          state_next    = (wait_load == 32'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt <= 32'd1) begin
          wait_cnt_next = 32'd0;
          state_next    = RESP;
        end else begin
          wait_cnt_next = wait_cnt - 32'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 32'd0;
      req_addr    <= 3'd0;
      req_wdata   <= 32'd0;
      req_wstrobe <= 4'd0;
      req_write   <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        req_addr    <= address[4:2];
        req_wdata   <= wdata;
        req_wstrobe <= wstrobe;
        req_write   <= wrequest;
      end
    end
  end

  // A write lands on the edge entering RESP, so its effect is visible alongside wresponse.
  // With a single wait state that edge is the accepting one, hence the bypass of the latches.
  assign cur_addr    = (state == IDLE) ? address[4:2] : req_addr;
  assign cur_wdata   = (state == IDLE) ? wdata        : req_wdata;
  assign cur_wstrobe = (state == IDLE) ? wstrobe      : req_wstrobe;
  assign cur_write   = (state == IDLE) ? wrequest     : req_write;
  assign commit      = (state_next == RESP) && cur_write;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{cur_wstrobe[gi]}};
    end
  endgenerate

  assign merged_tohost = (tohost    & ~wmask) | (cur_wdata & wmask);
  assign merged_begin  = (sig_begin & ~wmask) | (cur_wdata & wmask);
  assign merged_end    = (sig_end   & ~wmask) | (cur_wdata & wmask);

  assign tohost_hit  = commit && (cur_addr == 3'd0) && !done && (merged_tohost != 32'd0);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !done && (cycle_cnt == TIMEOUT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tohost    <= 32'd0;
      sig_begin <= 32'd0;
      sig_end   <= 32'd0;
      cycle_cnt <= 64'd0;
      hi_snap   <= 32'd0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
      fail_code <= 31'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (commit) begin
        case (cur_addr)
          3'd0:    tohost    <= merged_tohost;
          3'd1:    sig_begin <= merged_begin;
          3'd2:    sig_end   <= merged_end;
          default: ;
        endcase
      end
      if (tohost_hit) begin
        done <= 1'b1;
        if (merged_tohost == 32'd1) pass <= 1'b1;
        else                        fail_code <= merged_tohost[31:1];
      end else if (timeout_hit) begin
        done      <= 1'b1;
        timed_out <= 1'b1;
      end
      // CYCLE_HI returns the upper half as it was when CYCLE_LO was read.
      if (state == RESP && !req_write && req_addr == 3'd3)
        hi_snap <= cycle_cnt[63:32];
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (req_addr)
      3'd0:    rd_mux = tohost;
      3'd1:    rd_mux = sig_begin;
      3'd2:    rd_mux = sig_end;
      3'd3:    rd_mux = cycle_cnt[31:0];
      3'd4:    rd_mux = hi_snap;
      3'd5:    rd_mux = {29'd0, timed_out, pass, done};
      3'd6:    rd_mux = stall_rd;
      default: rd_mux = 32'd0;
    endcase
  end

  assign rresponse = (state == RESP) && !req_write;
  assign wresponse = (state == RESP) && req_write;
  assign rdata     = rresponse ? rd_mux : 32'd0;
  assign test_done = done;
  assign test_pass = pass;

endmodule

// File: tb/tb_rvx_test_host.sv
// Directed bench for rvx_test_host: one DUT with 3 wait states and a 100-cycle timeout,
// a second with WAIT_STATES=0 (behaves as 1) and the timeout disabled.
module tb_rvx_test_host;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address, wdata;
  logic [3:0]  wstrobe;
  logic        rrequest, wrequest;

  logic [31:0] a_rdata, b_rdata;
  logic        a_rresponse, a_wresponse, b_rresponse, b_wresponse;
  logic        a_done, a_pass, b_done, b_pass;
  logic [30:0] a_fail, b_fail;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] tb_cyc;

  always #5 clock = ~clock;

  rvx_test_host #(.WAIT_STATES(3), .TIMEOUT_CYCLES(100)) dut_a (
    .clock(clock), .reset(reset), .address(address), .rrequest(rrequest),
    .rdata(a_rdata), .rresponse(a_rresponse), .wdata(wdata), .wstrobe(wstrobe),
    .wrequest(wrequest), .wresponse(a_wresponse), .test_done(a_done),
    .test_pass(a_pass), .fail_code(a_fail)
  );

  rvx_test_host #(.WAIT_STATES(0), .TIMEOUT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .address(address), .rrequest(rrequest),
    .rdata(b_rdata), .rresponse(b_rresponse), .wdata(wdata), .wstrobe(wstrobe),
    .wrequest(wrequest), .wresponse(b_wresponse), .test_done(b_done),
    .test_pass(b_pass), .fail_code(b_fail)
  );

  // Independent count of edges since reset release, for the cycle counter check.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_cyc <= 64'd0;
    else       tb_cyc <= tb_cyc + 64'd1;
  end

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    int          lat;
    logic [31:0] rd;
    logic        rr;
    logic        wr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; rrequest = 1'b0; wrequest = 1'b0;
    address = 32'd0; wdata = 32'd0; wstrobe = 4'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Issues one request and returns at the negedge where a response is seen
  // (lat counts negedges after the accepting edge; 0 means none within the bound).
  task automatic bus_op(input int which, input logic w, input logic r,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                        output int lat, output logic [31:0] rd, output logic got_r, output logic got_w);
    lat = 0; rd = 32'd0; got_r = 1'b0; got_w = 1'b0;
    @(negedge clock);
    address = addr; wdata = wd; wstrobe = strb; wrequest = w; rrequest = r;
    @(posedge clock);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) begin wrequest = 1'b0; rrequest = 1'b0; end
      if (which == 0) begin got_r = a_rresponse; got_w = a_wresponse; rd = a_rdata; end
      else            begin got_r = b_rresponse; got_w = b_wresponse; rd = b_rdata; end
      if (got_r || got_w) begin lat = i; break; end
    end
    $display("op dut=%0d w=%0b r=%0b addr=0x%08h wdata=0x%08h strb=%b lat=%0d rresp=%0b wresp=%0b rdata=0x%08h",
             which, w, r, addr, wd, strb, lat, got_r, got_w, rd);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        gr, gw;
    int          pulses;

    vecs[0]  = '{1'b1, 1'b0, 32'h04,  32'h00002000, 4'hF,    3, 32'h0,        1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 32'h04,  32'h0,        4'h0,    3, 32'h00002000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h08,  32'h0,        4'h0,    3, 32'h0,        1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h08,  32'hAABBCCDD, 4'b0010, 3, 32'h0,        1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h08,  32'h0,        4'h0,    3, 32'h0000CC00, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h08,  32'h11223344, 4'b0001, 3, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h08,  32'h0,        4'h0,    3, 32'h0000CC44, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h1C,  32'hFFFFFFFF, 4'hF,    3, 32'h0,        1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h1C,  32'h0,        4'h0,    3, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h18,  32'h0,        4'h0,    3, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h104, 32'h0,        4'h0,    3, 32'h00002000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h14,  32'h0,        4'h0,    3, 32'h0,        1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h00,  32'h0,        4'hF,    3, 32'h0,        1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h14,  32'h0,        4'h0,    3, 32'h0,        1'b1, 1'b0};

    reset = 1'b1; rrequest = 1'b0; wrequest = 1'b0;
    address = 32'd0; wdata = 32'd0; wstrobe = 4'd0;
    #12;
    check("reset_rdata", a_rdata, 0);
    check("reset_resp", {a_rresponse, a_wresponse}, 0);
    check("reset_status", {a_done, a_pass, a_fail}, 0);

    // Table-driven register access, all on the 3-wait-state DUT.
    do_reset();
    foreach (vecs[k]) begin
      bus_op(0, vecs[k].w, vecs[k].r, vecs[k].addr, vecs[k].wd, vecs[k].strb, lat, rd, gr, gw);
      check($sformatf("vec%0d_latency", k), lat, vecs[k].lat);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].rd);
      check($sformatf("vec%0d_rresponse", k), gr, vecs[k].rr);
      check($sformatf("vec%0d_wresponse", k), gw, vecs[k].wr);
    end

    // Pass write, then a later fail-looking write must not change status.
    do_reset();
    bus_op(0, 1'b1, 1'b0, 32'h00, 32'h00000001, 4'hF, lat, rd, gr, gw);
    check("pass_done", a_done, 1);
    check("pass_pass", a_pass, 1);
    bus_op(0, 1'b1, 1'b0, 32'h00, 32'h00000006, 4'hF, lat, rd, gr, gw);
    check("frozen_status", {a_done, a_pass, a_fail}, {2'b11, 31'd0});
    bus_op(0, 1'b0, 1'b1, 32'h00, 32'h0, 4'h0, lat, rd, gr, gw);
    check("tohost_still_writable", rd, 32'h6);
    bus_op(0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0, lat, rd, gr, gw);
    check("pass_status_reg", rd, 32'h3);

    // Fail write captures tohost[31:1].
    do_reset();
    bus_op(0, 1'b1, 1'b0, 32'h00, 32'h0000000B, 4'hF, lat, rd, gr, gw);
    check("fail_status", {a_done, a_pass, a_fail}, {2'b10, 31'd5});
    bus_op(0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0, lat, rd, gr, gw);
    check("fail_status_reg", rd, 32'h1);
    bus_op(0, 1'b1, 1'b0, 32'h00, 32'h00000001, 4'hF, lat, rd, gr, gw);
    check("fail_frozen", {a_done, a_pass, a_fail}, {2'b10, 31'd5});

    // Timeout at 100 cycles on dut_a; dut_b has it disabled.
    do_reset();
    repeat (99) @(negedge clock);
    check("timeout_not_yet", a_done, 0);
    @(negedge clock);
    check("timeout_done", {a_done, a_pass}, 2'b10);
    check("no_timeout_b", b_done, 0);
    bus_op(0, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0, lat, rd, gr, gw);
    check("timeout_status_reg", rd, 32'h5);
    repeat (100) @(negedge clock);
    check("no_timeout_b_late", b_done, 0);

    // WAIT_STATES=0 behaves as a single wait state.
    do_reset();
    bus_op(1, 1'b1, 1'b0, 32'h04, 32'h00000055, 4'hF, lat, rd, gr, gw);
    check("b_write_latency", lat, 1);
    check("b_wresponse", gw, 1);
    bus_op(1, 1'b0, 1'b1, 32'h04, 32'h0, 4'h0, lat, rd, gr, gw);
    check("b_read_latency", lat, 1);
    check("b_read_data", rd, 32'h55);

    // Reset during WAIT drops the pending response and clears status.
    do_reset();
    bus_op(0, 1'b1, 1'b0, 32'h00, 32'h0000000B, 4'hF, lat, rd, gr, gw);
    @(negedge clock);
    address = 32'h04; rrequest = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rrequest = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("midreset_outputs", {a_rdata, a_rresponse, a_wresponse, a_done, a_pass, a_fail}, 0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (a_rresponse || a_wresponse) pulses++;
    end
    check("midreset_no_response", pulses, 0);
    bus_op(0, 1'b0, 1'b1, 32'h0C, 32'h0, 4'h0, lat, rd, gr, gw);
    check("cycle_lo", rd, tb_cyc[31:0]);
    bus_op(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, rd, gr, gw);
    check("cycle_hi", rd, 32'h0);
    check("cycle_hi_resp", gr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvx_test_host.md
Name: rvx_test_host

Overview:
- Memory-mapped responder on the RVX data-bus protocol: address, rdata, rrequest, rresponse, wdata, wstrobe, wrequest, wresponse.
- Sits behind the dbus address decoder as the simulation/FPGA test-host peripheral.
- Captures the tohost pass/fail write, holds the signature begin/end pointers and a free-running cycle counter, and flags a hang timeout.
- Injects a programmable number of wait states so initiator stall handling is exercised in hardware.

Parameters:
- WAIT_STATES, 1: fixed response latency in cycles after the request is accepted; minimum 1, 0 is treated as 1.
- TIMEOUT_CYCLES, 500000: cycle count at which a hang is declared; 0 disables the timeout.

Ports:
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high reset
- address  in  32  byte address; only address[4:2] is decoded
- rrequest  in  1  read request, single-cycle pulse
- rdata  out  32  read data, valid while rresponse=1
- rresponse  out  1  read completion pulse
- wdata  in  32  write data
- wstrobe  in  4  byte enables for wdata
- wrequest  in  1  write request, single-cycle pulse
- wresponse  out  1  write completion pulse
- test_done  out  1  sticky; set on tohost write or timeout
- test_pass  out  1  sticky; valid when test_done=1
- fail_code  out  31  tohost[31:1] captured on a fail write

Behaviour:
- Reset values: rdata=0, rresponse=0, wresponse=0, test_done=0, test_pass=0, fail_code=0. All registers and the cycle counter clear to 0.
- Register map (offset):
  - 0x00 TOHOST: RW
  - 0x04 SIG_BEGIN: RW
  - 0x08 SIG_END: RW
  - 0x0C CYCLE_LO: RO
  - 0x10 CYCLE_HI: RO
  - 0x14 STATUS: RO; bit0 done, bit1 pass, bit2 timeout
  - 0x18, 0x1C: read 0, writes ignored, still acknowledged.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is accepted in any cycle rrequest or wrequest is high.
  - address, wdata, wstrobe and the request type are latched on acceptance; wait counter loads WAIT_STATES-1.
  - Next state is RESP if WAIT_STATES<=1, else WAIT.
- WAIT: counter decrements each cycle; move to RESP when it reaches 0.
- RESP:
  - Writes: the write is committed, then wresponse=1 for exactly one cycle.
  - Reads: rdata is driven and rresponse=1 for exactly one cycle.
  - Next state is IDLE.
  - Total latency from accepted request to response is WAIT_STATES cycles.
- Requests arriving outside IDLE are ignored; the initiator must wait for the response.
- rrequest and wrequest high in the same cycle: the write is served, the read is dropped, and no rresponse is produced.
- Write strobes apply per byte to TOHOST, SIG_BEGIN and SIG_END.
- TOHOST evaluation uses the merged word, and only while test_done=0:
  - value 1: test_done=1, test_pass=1.
  - other nonzero value: test_done=1, test_pass=0, fail_code=value[31:1].
  - value 0: no status change.
- After test_done=1, TOHOST remains writable, but test_done, test_pass and fail_code are frozen until reset.
- Cycle counter:
  - 64-bit, increments every cycle after reset, wraps 2^64-1 -> 0.
  - Reading CYCLE_LO snapshots the upper half; CYCLE_HI returns that snapshot, giving a coherent 64-bit pair.
- Timeout: when TIMEOUT_CYCLES!=0, test_done=0, and counter==TIMEOUT_CYCLES-1, set test_done=1, test_pass=0, STATUS.timeout=1 on the next edge. A tohost write committing in the same cycle takes priority.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, the pending response is dropped, and all outputs return to reset values asynchronously.

Optional Feature:
- Macro: RVX_TEST_HOST_RANDOM_STALL_EN.
- When defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle. On acceptance, LFSR[1:0] extra cycles (0..3) are added to the wait count; the LFSR value applied is readable at offset 0x18 bits[1:0].
- When undefined: latency is exactly WAIT_STATES, offset 0x18 reads 0, and no LFSR logic is present.

Test Plan:
- Reset, then WAIT_STATES=3, write SIG_BEGIN=0x00002000 with wstrobe=4'hF, read it back -> wresponse exactly 3 cycles after wrequest; rdata=0x00002000 with rresponse 3 cycles after rrequest.
- Write TOHOST=0x00000001 -> test_done=1, test_pass=1 on the next edge; a later write of 0x00000006 leaves test_pass=1 and fail_code=0.
- After reset, write TOHOST=0x0000000B -> test_done=1, test_pass=0, fail_code=5; STATUS reads 0x1.
- TIMEOUT_CYCLES=100, no writes -> test_done=1, test_pass=0 after cycle 100; STATUS reads 0x5.
- Write SIG_END with wstrobe=4'b0010, wdata=0xAABBCCDD, over prior 0 -> reads 0x0000CC00. Simultaneous rrequest+wrequest -> only wresponse pulses.
- Assert reset during WAIT -> no response pulse, all outputs 0. A fresh read of CYCLE_LO then CYCLE_HI returns a consistent pair (HI=0).
